// File: rtl/spad_gate_pwm_gen_if.sv
// rtl/spad_gate_pwm_gen_if.sv - config handshake bundle for the SPAD gate pulse generator
//
// Ports (signals):
//   cfg_valid   : config offer (master -> slave)
//   cfg_ready   : config accept window (slave -> master)
//   cfg_period  : new period in clk cycles
//   cfg_q_width : new quench pulse width
//   cfg_r_delay : new reset pulse start phase
//   cfg_r_width : new reset pulse width
//   cfg_err     : one-cycle pulse when an offered config was rejected
interface spad_gate_pwm_gen_if #(
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_q_width;
  logic [CNT_W-1:0] cfg_r_delay;
  logic [CNT_W-1:0] cfg_r_width;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_period, cfg_q_width, cfg_r_delay, cfg_r_width,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_q_width, cfg_r_delay, cfg_r_width,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/spad_gate_pwm_gen.sv
// rtl/spad_gate_pwm_gen.sv - programmable quench/reset pulse-train generator for the SPAD front end
//
// Ports:
//   clk, rst_n    : 50 MHz clock, asynchronous active-low reset
//   enable        : run request
//   mode          : 0 = free-run, 1 = single-shot
//   trig          : single-shot start (level-sampled in IDLE only)
//   rst_out_mask  : 1 forces the reset path off
//   cfg           : config handshake (slave side)
//   quench_en_n   : quench driver enable, active-low
//   quench_pwm    : quench pulse
//   rst_en        : reset driver enable
//   rst_pwm       : reset pulse
//   busy          : state is not IDLE
//   led           : period heartbeat counter
module spad_gate_pwm_gen #(
  parameter int CNT_W       = 16,
  parameter int DEF_PERIOD  = 24,
  parameter int DEF_Q_WIDTH = 12,
  parameter int DEF_R_DELAY = 12,
  parameter int DEF_R_WIDTH = 4,
  parameter int LED_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               mode,
  input  logic               trig,
  input  logic               rst_out_mask,
  spad_gate_pwm_gen_if.slave cfg,
  output logic               quench_en_n,
  output logic               quench_pwm,
  output logic               rst_en,
  output logic               rst_pwm,
  output logic               busy,
  output logic [LED_W-1:0]   led
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] phase, phase_nxt;
  logic [CNT_W-1:0] period, q_width, r_delay, r_width;
  logic             wrap;
  logic             ready;
  logic             xfer;
  logic             cfg_ok;
  logic [CNT_W:0]   r_end;
  logic [CNT_W:0]   cfg_r_end;

  // One bit wider than the timing fields so delay + width cannot wrap.
  assign r_end     = {1'b0, r_delay} + {1'b0, r_width};
  assign cfg_r_end = {1'b0, cfg.cfg_r_delay} + {1'b0, cfg.cfg_r_width};

  assign cfg_ok = (cfg.cfg_period >= CNT_W'(2)) &&
                  (cfg.cfg_q_width < cfg.cfg_period) &&
                  (cfg_r_end <= {1'b0, cfg.cfg_period});

  assign xfer          = cfg.cfg_valid && ready;
  assign cfg.cfg_ready = ready;
  assign busy          = (state != IDLE);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    wrap      = 1'b0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready     = 1'b1;
        phase_nxt = '0;
        if (enable && (!mode || trig)) state_nxt = RUN;
      end
      RUN: begin
        // Mode, trig and enable are only looked at on the last phase, so a
        // period is never cut short and a trig during RUN is simply dropped.
        wrap  = (phase == period - CNT_W'(1));
        ready = wrap;
        if (wrap) begin
          phase_nxt = '0;
          if (!enable || mode) state_nxt = IDLE;
        end else begin
          phase_nxt = phase + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // A config is only taken in IDLE or on the last phase, so writing it
  // straight into the active set makes it apply from the next period start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period  <= CNT_W'(DEF_PERIOD);
      q_width <= CNT_W'(DEF_Q_WIDTH);
      r_delay <= CNT_W'(DEF_R_DELAY);
      r_width <= CNT_W'(DEF_R_WIDTH);
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer && !cfg_ok;
      if (xfer && cfg_ok) begin
        period  <= cfg.cfg_period;
        q_width <= cfg.cfg_q_width;
        r_delay <= cfg.cfg_r_delay;
        r_width <= cfg.cfg_r_width;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '1;
    end else if (wrap) begin
      led <= led + LED_W'(1);
    end
  end

  // Registered decode: outputs show the phase of the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quench_pwm  <= 1'b0;
      rst_pwm     <= 1'b0;
      quench_en_n <= 1'b1;
      rst_en      <= 1'b0;
    end else begin
      quench_pwm  <= (state == RUN) && (phase < q_width);
      rst_pwm     <= (state == RUN) && !rst_out_mask &&
                     ({1'b0, phase} >= {1'b0, r_delay}) && ({1'b0, phase} < r_end);
      quench_en_n <= (state != RUN);
      rst_en      <= (state == RUN) && !rst_out_mask;
    end
  end

endmodule

// File: doc/spad_gate_pwm_gen.md
Name: spad_gate_pwm_gen

Overview:
- Parametrised quench/reset pulse-train generator for the SPAD front end; successor to the fixed-divider quench toggler.
- Per period, produces one quench pulse and one independently positioned reset pulse. Period, widths and delay are programmable through a config handshake.
- Supports free-running and single-shot (triggered) modes, a reset-output safety mask, and a period-heartbeat LED counter.
- Sits between the CPLD top-level pins and the board control interface.

Parameters:
- CNT_W, 16: width of the phase counter and all timing fields.
- DEF_PERIOD, 24: period after reset, in clk cycles (50 MHz / 24 = 2.083 MHz).
- DEF_Q_WIDTH, 12: quench pulse width after reset, in cycles.
- DEF_R_DELAY, 12: reset pulse start phase after reset.
- DEF_R_WIDTH, 4: reset pulse width after reset, in cycles.
- LED_W, 4: width of the heartbeat counter.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: run request.
- mode, input, 1: 0 = free-run, 1 = single-shot.
- trig, input, 1: single-shot start, level-sampled.
- cfg_valid, input, 1: config offer.
- cfg_ready, output, 1: config accept window.
- cfg_period, input, CNT_W: new period.
- cfg_q_width, input, CNT_W: new quench width.
- cfg_r_delay, input, CNT_W: new reset delay.
- cfg_r_width, input, CNT_W: new reset width.
- cfg_err, output, 1: one-cycle pulse when an offered config is rejected.
- rst_out_mask, input, 1: 1 forces the reset path off (board fault on the rst_pwm net).
- quench_en_n, output, 1: quench driver enable, active-low.
- quench_pwm, output, 1: quench pulse.
- rst_en, output, 1: reset driver enable, active-high.
- rst_pwm, output, 1: reset pulse.
- busy, output, 1: state is not IDLE.
- led, output, LED_W: heartbeat counter.

Behaviour:
- Reset values:
  - Active config = DEF_* values.
  - State IDLE, phase = 0.
  - quench_pwm = 0, rst_pwm = 0, rst_en = 0, quench_en_n = 1, busy = 0, cfg_err = 0.
  - led = all ones.
- Reset asserted mid-operation aborts immediately to these values; no pulse completion.
- States:
  - IDLE → RUN when enable = 1 and (mode = 0, or mode = 1 and trig = 1). Phase starts at 0 on the entry cycle.
  - RUN: phase increments each cycle and wraps period-1 → 0. At the wrap:
    - led increments (wraps from all ones to 0).
    - If enable = 0, or mode = 1, go to IDLE; otherwise stay in RUN.
  - enable deassertion mid-period never truncates a pulse; the current period always completes.
  - mode and trig changes during RUN take effect only at the wrap.
- Pulse decode, registered (outputs lag phase by exactly 1 cycle):
  - quench_pwm = 1 iff RUN and phase < q_width.
  - rst_pwm = 1 iff RUN, rst_out_mask = 0, and r_delay ≤ phase < r_delay + r_width.
  - The comparison sum uses CNT_W+1 bits, so there is no overflow.
- Enables, registered:
  - quench_en_n = 0 iff state is RUN.
  - rst_en = 1 iff state is RUN and rst_out_mask = 0.
  - rst_out_mask takes effect on the next cycle and overrides everything.
- Config handshake:
  - cfg_ready = 1 in IDLE, and in RUN only on the cycle with phase = period-1.
  - Transfer occurs on cfg_valid and cfg_ready. A new config applies from the next period start; the current period is never altered.
  - Validity (all must hold): period ≥ 2; q_width < period; r_delay + r_width ≤ period.
  - Invalid config: the handshake still completes, the active config is unchanged, and cfg_err = 1 on the following cycle.
  - Zero widths are legal and suppress that pulse.
- Simultaneous events:
  - Config accepted on the wrap cycle together with enable = 0: the config is stored and the state goes to IDLE.
  - A trig that arrives while in RUN is ignored, not queued.

Test Plan:
- Defaults, enable = 1, mode = 0: quench_pwm is high for 12 of every 24 cycles. rst_pwm is high at phases 12–15, seen on outputs 1 cycle later. led goes 1111 → 0000 → 0001 on successive wraps.
- Config period = 10, q_width = 3, r_delay = 5, r_width = 5, offered mid-period: cfg_ready stays low until phase 23. The next period is 10 cycles, with quench at phases 0–2 and reset at phases 5–9.
- Config period = 8, q_width = 8, offered in IDLE: cfg_err pulses once. Output still shows the 24-cycle period. Separately, period = 1 → cfg_err.
- mode = 1, trig pulsed once: exactly one period is produced, then busy drops. A trig asserted during RUN produces no second period.
- enable dropped at phase 5 in free-run: the period runs to phase 23, then IDLE with quench_en_n = 1. rst_out_mask = 1 mid-pulse: rst_pwm and rst_en are 0 on the next cycle while quench continues.
- rst_n asserted at phase 7 mid-quench: all outputs return to reset values immediately. After release, defaults are restored, led = 1111, and any previously loaded config is discarded.
